// File: rtl/alu_sequencer_pkg.sv
// Shared types and helpers for the ALU sequencer and its flag generator.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_NOT = 4'd4,
      OP_XOR = 4'd5,
      OP_LSL = 4'd6,
      OP_LSR = 4'd7,
      OP_ASL = 4'd8,
      OP_ASR = 4'd9
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   function automatic logic is_legal(input logic [3:0] op);
      return op <= 4'd9;
   endfunction

   function automatic logic is_shift(input logic [3:0] op);
      return (op >= 4'd6) && (op <= 4'd9);
   endfunction

   function automatic logic is_left(input op_e op);
      return (op == OP_LSL) || (op == OP_ASL);
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, response and ALU-drive signals of the sequencer, grouped as one bus.
interface alu_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [3:0]       alu_sel;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_result;
   logic [3:0]       resp_flags;
   logic             resp_err;

   // Sequencer side.
   modport master (
      input  req_valid, req_op, req_a, req_b, alu_result, alu_cout, resp_ready,
      output req_ready, alu_sel, alu_a, alu_b, resp_valid, resp_result, resp_flags, resp_err
   );

   // Decode stage / ALU / response consumer side.
   modport slave (
      output req_valid, req_op, req_a, req_b, alu_result, alu_cout, resp_ready,
      input  req_ready, alu_sel, alu_a, alu_b, resp_valid, resp_result, resp_flags, resp_err
   );
endinterface

// File: rtl/alu_sequencer_flag_gen.sv
// Combinational Z/N/C/V for the final ALU step of an operation.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op_i,
   input  logic             a_sign_i,
   input  logic             b_sign_i,
   input  logic [WIDTH-1:0] result_i,
   input  logic             cout_i,
   input  logic             sh_out_i,
   input  logic             asl_v_i,
   output logic [3:0]       flags_o
);

   logic c;
   logic v;
   logic r_sign;

   assign r_sign = result_i[WIDTH-1];

   // Carry/overflow depend on the operation class; Z/N always follow the result.
   always_comb begin
      c = 1'b0;
      v = 1'b0;
      case (op_i)
         OP_ADD: begin
            c = cout_i;
            v = (a_sign_i == b_sign_i) && (r_sign != a_sign_i);
         end
         OP_SUB: begin
            c = cout_i;
            v = (a_sign_i != b_sign_i) && (r_sign != a_sign_i);
         end
         OP_LSL, OP_LSR, OP_ASR: c = sh_out_i;
         OP_ASL: begin
            c = sh_out_i;
            // sticky sign change from earlier steps plus this final step
            v = asl_v_i | (a_sign_i ^ r_sign);
         end
         default: ;
      endcase
      flags_o        = '0;
      flags_o[FLG_Z] = ~|result_i;
      flags_o[FLG_N] = r_sign;
      flags_o[FLG_C] = c;
      flags_o[FLG_V] = v;
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller in front of an external ALU: one op per request,
// multi-bit shifts iterated as single-bit ALU steps, flags and result returned
// through a response handshake.
//
//  state | meaning
//  IDLE  | req_ready high, waiting for a request
//  EXEC  | driving the ALU, one step per cycle until shcnt reaches 1
//  DONE  | response held until resp_ready
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   alu_sequencer_if.master bus
);

   localparam int SHW = $clog2(WIDTH);

   state_e           state_q;
   op_e              op_q;
   logic [SHW-1:0]   shcnt_q;
   logic             shz_q;
   logic             asl_v_q;
   logic [3:0]       alu_sel_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic             resp_valid_q;
   logic [WIDTH-1:0] resp_result_q;
   logic [3:0]       resp_flags_q;
   logic             resp_err_q;

   logic [SHW-1:0]   shamt;
   logic             sh_out;
   logic [3:0]       flags;

   assign shamt = bus.req_b[SHW-1:0];

   // Bit leaving the accumulator on this step; a zero-length shift moves nothing out.
   assign sh_out = shz_q ? 1'b0 : (is_left(op_q) ? alu_a_q[WIDTH-1] : alu_a_q[0]);

   alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
      .op_i     (op_q),
      .a_sign_i (alu_a_q[WIDTH-1]),
      .b_sign_i (alu_b_q[WIDTH-1]),
      .result_i (bus.alu_result),
      .cout_i   (bus.alu_cout),
      .sh_out_i (sh_out),
      .asl_v_i  (asl_v_q),
      .flags_o  (flags)
   );

   // Sequencing FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= OP_ADD;
         shcnt_q       <= '0;
         shz_q         <= 1'b0;
         asl_v_q       <= 1'b0;
         alu_sel_q     <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_flags_q  <= '0;
         resp_err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  if (!is_legal(bus.req_op)) begin
                     state_q       <= ST_DONE;
                     resp_valid_q  <= 1'b1;
                     resp_result_q <= '0;
                     resp_flags_q  <= '0;
                     resp_err_q    <= 1'b1;
                  end else begin
                     state_q <= ST_EXEC;
                     op_q    <= op_e'(bus.req_op);
                     alu_a_q <= bus.req_a;
                     asl_v_q <= 1'b0;
                     shz_q   <= 1'b0;
                     if (is_shift(bus.req_op)) begin
                        if (shamt == '0) begin
                           // OR with zero passes A through in a single step
                           alu_sel_q <= OP_OR;
                           alu_b_q   <= '0;
                           shcnt_q   <= SHW'(1);
                           shz_q     <= 1'b1;
                        end else begin
                           alu_sel_q <= bus.req_op;
                           alu_b_q   <= WIDTH'(1);
                           shcnt_q   <= shamt;
                        end
                     end else begin
                        alu_sel_q <= bus.req_op;
                        alu_b_q   <= bus.req_b;
                        shcnt_q   <= SHW'(1);
                     end
                  end
               end
            end
            ST_EXEC: begin
               alu_a_q <= bus.alu_result;
               shcnt_q <= shcnt_q - SHW'(1);
               asl_v_q <= asl_v_q | (alu_a_q[WIDTH-1] ^ bus.alu_result[WIDTH-1]);
               if (shcnt_q == SHW'(1)) begin
                  state_q       <= ST_DONE;
                  resp_valid_q  <= 1'b1;
                  resp_result_q <= bus.alu_result;
                  resp_flags_q  <= flags;
                  resp_err_q    <= 1'b0;
                  alu_sel_q     <= '0;
                  alu_a_q       <= '0;
                  alu_b_q       <= '0;
               end
            end
            ST_DONE: begin
               if (bus.resp_ready) begin
                  state_q      <= ST_IDLE;
                  resp_valid_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = (state_q == ST_IDLE);
   assign bus.alu_sel     = alu_sel_q;
   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = resp_result_q;
   assign bus.resp_flags  = resp_flags_q;
   assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and random checks of alu_sequencer against a behavioural ALU and
// a whole-operation reference model, with a queue of expected responses.
module tb_alu_sequencer;

   typedef struct {
      logic [7:0] result;
      logic [3:0] flags;
      logic       err;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t sb[$];

   alu_sequencer_if #(.WIDTH(8)) bus ();

   alu_sequencer #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural combinational ALU.
   logic [8:0] alu_t;
   always_comb begin
      alu_t          = '0;
      bus.alu_result = '0;
      bus.alu_cout   = 1'b0;
      case (bus.alu_sel)
         4'd0: begin
            alu_t          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_result = alu_t[7:0];
            bus.alu_cout   = alu_t[8];
         end
         4'd1: begin
            alu_t          = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            bus.alu_result = alu_t[7:0];
            bus.alu_cout   = ~alu_t[8];
         end
         4'd2: bus.alu_result = bus.alu_a & bus.alu_b;
         4'd3: bus.alu_result = bus.alu_a | bus.alu_b;
         4'd4: bus.alu_result = ~bus.alu_a;
         4'd5: bus.alu_result = bus.alu_a ^ bus.alu_b;
         4'd6, 4'd8: bus.alu_result = bus.alu_a << bus.alu_b[2:0];
         4'd7: bus.alu_result = bus.alu_a >> bus.alu_b[2:0];
         4'd9: bus.alu_result = 8'($signed(bus.alu_a) >>> bus.alu_b[2:0]);
         default: ;
      endcase
   end

   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t       e;
      logic [8:0] t;
      logic [7:0] x;
      logic [7:0] nx;
      logic       c;
      logic       v;
      int         n;
      x = '0; c = 1'b0; v = 1'b0; e.err = 1'b0;
      n = int'(b[2:0]);
      case (op)
         4'd0: begin
            t = {1'b0, a} + {1'b0, b}; x = t[7:0]; c = t[8];
            v = (a[7] == b[7]) && (x[7] != a[7]);
         end
         4'd1: begin
            x = a - b; c = (a >= b);
            v = (a[7] != b[7]) && (x[7] != a[7]);
         end
         4'd2: x = a & b;
         4'd3: x = a | b;
         4'd4: x = ~a;
         4'd5: x = a ^ b;
         4'd6, 4'd7, 4'd8, 4'd9: begin
            x = a;
            for (int i = 0; i < n; i++) begin
               if (op == 4'd6 || op == 4'd8) begin
                  c = x[7]; nx = {x[6:0], 1'b0};
                  if (op == 4'd8 && nx[7] != x[7]) v = 1'b1;
                  x = nx;
               end else if (op == 4'd7) begin
                  c = x[0]; x = {1'b0, x[7:1]};
               end else begin
                  c = x[0]; x = {x[7], x[7:1]};
               end
            end
         end
         default: e.err = 1'b1;
      endcase
      e.result = x;
      e.flags  = e.err ? 4'b0000 : {(x == 8'h00), x[7], c, v};
      return e;
   endfunction

   function automatic int lat_of(input logic [3:0] op, input logic [7:0] b);
      if (op > 4'd9) return 1;
      if (op >= 4'd6 && b[2:0] != 3'd0) return 1 + int'(b[2:0]);
      return 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive a request in the current cycle (called at a negedge).
   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_valid = 1'b1;
   endtask

   task automatic expect_resp(input logic [7:0] r, input logic [3:0] f, input logic e);
      exp_t x;
      x.result = r; x.flags = f; x.err = e;
      sb.push_back(x);
   endtask

   // Wait for resp_valid counting cycles from the accept cycle, then score it.
   task automatic collect(input string tag, input int exp_lat, output logic sel_any);
      exp_t e;
      int   lat;
      sel_any = 1'b0;
      lat     = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) bus.req_valid = 1'b0;
         if (bus.alu_sel != 4'd0) sel_any = 1'b1;
      end while (!bus.resp_valid && lat < 40);
      chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_sbsize"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_result"}, 32'(bus.resp_result), 32'(e.result));
         chk({tag, "_flags"}, 32'(bus.resp_flags), 32'(e.flags));
         chk({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
      end
   endtask

   task automatic ack();
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("ack_req_ready", 32'(bus.req_ready), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] r, input logic [3:0] f,
                         input logic e);
      logic s;
      issue(op, a, b);
      expect_resp(r, f, e);
      collect(tag, lat_of(op, b), s);
      ack();
   endtask

   initial begin
      logic       s;
      logic       seen;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      exp_t       m;
      total = 0;
      bad   = 0;
      bus.req_valid  = 1'b0;
      bus.req_op     = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_result", 32'(bus.resp_result), 32'd0);
      chk("rst_resp_flags", 32'(bus.resp_flags), 32'd0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
      chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
      chk("rst_alu_b", 32'(bus.alu_b), 32'd0);

      // directed operations: flags are {Z,N,C,V}
      run_op("add_ovf", 4'd0, 8'h7F, 8'h01, 8'h80, 4'b0101, 1'b0);
      run_op("sub_eq",  4'd1, 8'h05, 8'h05, 8'h00, 4'b1010, 1'b0);
      run_op("xor",     4'd5, 8'hF0, 8'hFF, 8'h0F, 4'b0000, 1'b0);
      run_op("lsr3",    4'd7, 8'h81, 8'h03, 8'h10, 4'b0000, 1'b0);
      run_op("asr2",    4'd9, 8'h80, 8'h02, 8'hE0, 4'b0100, 1'b0);
      run_op("lsl0",    4'd6, 8'h5A, 8'h00, 8'h5A, 4'b0000, 1'b0);
      run_op("sub_brw", 4'd1, 8'h03, 8'h05, 8'hFE, 4'b0100, 1'b0);
      run_op("asl1_v",  4'd8, 8'h40, 8'h01, 8'h80, 4'b0101, 1'b0);
      run_op("lsl_c",   4'd6, 8'h81, 8'hF9, 8'h02, 4'b0010, 1'b0);
      run_op("not",     4'd4, 8'h0F, 8'hAA, 8'hF0, 4'b0100, 1'b0);

      // illegal opcode: immediate error response, ALU never selected
      issue(4'hC, 8'h12, 8'h34);
      expect_resp(8'h00, 4'b0000, 1'b1);
      collect("illegal", 1, s);
      chk("illegal_alu_sel", 32'(s | (bus.alu_sel != 4'd0)), 32'd0);
      ack();

      // response back-pressure with a competing request
      issue(4'd2, 8'hF0, 8'h3C);
      expect_resp(8'h30, 4'b0000, 1'b0);
      collect("and_stall", 2, s);
      issue(4'd0, 8'h10, 8'h20);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(bus.resp_valid), 32'd1);
         chk("stall_result", 32'(bus.resp_result), 32'h30);
         chk("stall_flags", 32'(bus.resp_flags), 32'h0);
         chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("stall_accept_ready", 32'(bus.req_ready), 32'd1);
      expect_resp(8'h30, 4'b0000, 1'b0);
      collect("add_after_stall", 2, s);
      ack();

      // reset in the middle of a long shift
      issue(4'd6, 8'h01, 8'h07);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_no_valid", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("midrst_alu_sel", 32'(bus.alu_sel), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.resp_valid) seen = 1'b1;
      end
      chk("midrst_never_valid", 32'(seen), 32'd0);
      run_op("add_after_rst", 4'd0, 8'hFF, 8'h01, 8'h00, 4'b1010, 1'b0);

      // random operations, including illegal codes, scored against the model
      for (int i = 0; i < 16; i++) begin
         op = 4'($urandom_range(0, 11));
         a  = 8'($urandom);
         b  = 8'($urandom);
         m  = model(op, a, b);
         run_op("rand", op, a, b, m.result, m.flags, m.err);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
